ws2812_pattern_gen: RTL

Autonomous pattern source that drives the write port of the `ws2812` LED driver.

- Periodically generates a full frame of colour data, one write per LED, for solid, chase, rainbow or breathing animations.
- Sits directly upstream of `ws2812`. Its `led_num`/`rgb_data`/`write` outputs connect 1:1 to that block's inputs, replacing per-LED pokes from the logic analyser with a single mode/colour/period setting.

---
 rtl/ws2812_pattern_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ws2812_pattern_gen.sv
// ws2812_pattern_gen: autonomous frame source for the ws2812 LED driver.
// Each frame idles for max(period,1) cycles, then writes NUM_LEDS LEDs
// back-to-back, then pulses frame_done and advances the animation step.
// The rendered pattern is solid, chase, rainbow or breathe.
module ws2812_pattern_gen #(
    parameter int NUM_LEDS = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [23:0]         colour,
    input  logic [PERIOD_W-1:0] period,
    output logic [7:0]          led_num,
    output logic [23:0]         rgb_data,
    output logic                write,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(NUM_LEDS - 1);

    logic [1:0]          state;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] wait_last;
    logic [7:0]          idx;
    logic [7:0]          next_idx;
    logic [7:0]          step;
    logic [1:0]          frame_mode;
    logic [23:0]         frame_colour;
    logic [1:0]          pat_mode;
    logic [23:0]         pat_colour;
    logic [23:0]         pat_rgb;

    // Colour of LED i at animation step s; all arithmetic is 8-bit unsigned.
    function automatic logic [23:0] pattern(input logic [1:0]  m,
                                            input logic [23:0] c,
                                            input logic [7:0]  s,
                                            input logic [7:0]  i);
        logic [7:0]  h;
        logic [7:0]  hp;
        logic [7:0]  h3;
        logic [7:0]  b;
        logic [15:0] p2;
        logic [15:0] p1;
        logic [15:0] p0;
        h  = s + (i << 5);
        if (h < 8'd85)       hp = h;
        else if (h < 8'd170) hp = h - 8'd85;
        else                 hp = h - 8'd170;
        h3 = hp + {hp[6:0], 1'b0};
        b  = {s[7] ? ~s[6:0] : s[6:0], 1'b0};
        p2 = {8'd0, c[23:16]} * {8'd0, b};
        p1 = {8'd0, c[15:8]}  * {8'd0, b};
        p0 = {8'd0, c[7:0]}   * {8'd0, b};
        case (m)
            2'd0: pattern = c;
            2'd1: pattern = ({1'b0, i} == ({1'b0, s} % 9'(NUM_LEDS))) ? c : 24'h0;
            2'd2: begin
                if (h < 8'd85)       pattern = {8'd255 - h3, h3, 8'd0};
                else if (h < 8'd170) pattern = {8'd0, 8'd255 - h3, h3};
                else                 pattern = {h3, 8'd0, 8'd255 - h3};
            end
            default: pattern = {p2[15:8], p1[15:8], p0[15:8]};
        endcase
    endfunction

    // A period of 0 behaves as 1.
    assign wait_last = (period == '0) ? '0 : period - PERIOD_W'(1);
    assign next_idx  = (state == S_WRITE) ? idx + 8'd1 : 8'd0;
    assign pat_rgb   = pattern(pat_mode, pat_colour, step, next_idx);

    // LED 0 is rendered on the same edge that latches mode/colour, so it
    // takes the live inputs; later LEDs use the latched frame copy.
    always_comb begin
        pat_mode   = frame_mode;
        pat_colour = frame_colour;
        if (state == S_WAIT) begin
            pat_mode   = mode;
            pat_colour = colour;
        end
    end

    // Frame sequencer with registered write-port outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            step         <= '0;
            frame_mode   <= '0;
            frame_colour <= '0;
            led_num      <= '0;
            rgb_data     <= '0;
            write        <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            write      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (cnt == wait_last) begin
                        state        <= S_WRITE;
                        frame_mode   <= mode;
                        frame_colour <= colour;
                        idx          <= '0;
                        led_num      <= '0;
                        rgb_data     <= pat_rgb;
                        write        <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
                    end
                end
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else begin
                        idx      <= next_idx;
                        led_num  <= next_idx;
                        rgb_data <= pat_rgb;
                        write    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    step  <= step + 8'd1;
                    cnt   <= '0;
                    state <= enable ? S_WAIT : S_IDLE;
                end
            endcase
        end
    end

endmodule
